// File: rtl/vector_mac_unit.sv
// Vector execution stage: lane-wise signed Q1.7 add/mul/multiply-accumulate over two source vectors,
// LANESPERCYCLE lanes per cycle, followed by a single register-file write-back cycle.
module vector_mac_unit #(
  parameter int VECTORSPERREG = 16,
  parameter int DATAWIDTH     = 8,
  parameter int REGSIZEINT    = 5,
  parameter int LANESPERCYCLE = 4,
  parameter int ACCWIDTH      = 20,
  parameter int FRACBITS      = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         op,
  input  logic [REGSIZEINT-1:0]              rd_dst,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] va,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0] vb,
  output logic                               busy,
  output logic                               done,
  output logic                               we3,
  output logic [REGSIZEINT-1:0]              ra3,
  output logic [VECTORSPERREG*DATAWIDTH-1:0] wd3
);

  localparam int VW   = VECTORSPERREG * DATAWIDTH;
  localparam int G    = VECTORSPERREG / LANESPERCYCLE;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int LW   = (VECTORSPERREG > 1) ? $clog2(VECTORSPERREG) : 1;
  localparam int PW   = 2 * DATAWIDTH;
  localparam int WIDE = ACCWIDTH + 1;

  localparam logic [1:0] OP_VADD = 2'b00;
  localparam logic [1:0] OP_VMUL = 2'b01;
  localparam logic [1:0] OP_VMAC = 2'b10;
  localparam logic [1:0] OP_VCLR = 2'b11;

  localparam logic signed [WIDE-1:0] DW_MAX  = {{(WIDE-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [WIDE-1:0] DW_MIN  = ~DW_MAX;
  localparam logic signed [WIDE-1:0] ACC_MAX = {2'b00, {(ACCWIDTH-1){1'b1}}};
  localparam logic signed [WIDE-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic [GW-1:0]          G_LAST  = GW'(G - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  function automatic logic signed [DATAWIDTH-1:0] sat_dw(input logic signed [WIDE-1:0] x);
    if (x > DW_MAX)      return DW_MAX[DATAWIDTH-1:0];
    else if (x < DW_MIN) return DW_MIN[DATAWIDTH-1:0];
    else                 return x[DATAWIDTH-1:0];
  endfunction

  function automatic logic signed [ACCWIDTH-1:0] sat_acc(input logic signed [WIDE-1:0] x);
    if (x > ACC_MAX)      return ACC_MAX[ACCWIDTH-1:0];
    else if (x < ACC_MIN) return ACC_MIN[ACCWIDTH-1:0];
    else                  return x[ACCWIDTH-1:0];
  endfunction

  function automatic logic signed [WIDE-1:0] sext_prod(input logic signed [PW-1:0] x);
    return {{(WIDE-PW){x[PW-1]}}, x};
  endfunction

  function automatic logic signed [WIDE-1:0] sext_dw(input logic signed [DATAWIDTH-1:0] x);
    return {{(WIDE-DATAWIDTH){x[DATAWIDTH-1]}}, x};
  endfunction

  state_t                      r_state, w_state_nx;
  logic [GW-1:0]               r_g;
  logic [1:0]                  r_op;
  logic [REGSIZEINT-1:0]       r_dst;
  logic [VW-1:0]               r_va, r_vb, r_res;
  logic signed [ACCWIDTH-1:0]  r_acc [VECTORSPERREG];
  logic                        r_done, r_we3;
  logic [REGSIZEINT-1:0]       r_ra3;
  logic [VW-1:0]               r_wd3;
  logic                        w_accept;

  logic [LW-1:0]               w_lidx   [LANESPERCYCLE];
  logic signed [DATAWIDTH-1:0] w_res    [LANESPERCYCLE];
  logic signed [ACCWIDTH-1:0]  w_acc_nx [LANESPERCYCLE];

  // A start landing on the write-back pulse cycle is dropped, not queued
  assign w_accept = (r_state == S_IDLE) && start && !r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_EXEC;
      S_EXEC:  if (r_g == G_LAST) w_state_nx = S_WB;
      S_WB:    w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Per-lane arithmetic for the group selected by r_g
  always_comb begin
    for (int l = 0; l < LANESPERCYCLE; l++) begin
      logic signed [DATAWIDTH-1:0] a, b;
      logic signed [PW-1:0]        ax, bx, prod;
      logic signed [WIDE-1:0]      prod_w, acc_sum;
      w_lidx[l]   = LW'(int'(r_g) * LANESPERCYCLE + l);
      a           = r_va[w_lidx[l]*DATAWIDTH +: DATAWIDTH];
      b           = r_vb[w_lidx[l]*DATAWIDTH +: DATAWIDTH];
      ax          = {{(PW-DATAWIDTH){a[DATAWIDTH-1]}}, a};
      bx          = {{(PW-DATAWIDTH){b[DATAWIDTH-1]}}, b};
      prod        = ax * bx;
      prod_w      = sext_prod(prod);
      acc_sum     = {r_acc[w_lidx[l]][ACCWIDTH-1], r_acc[w_lidx[l]]} + prod_w;
      w_acc_nx[l] = sat_acc(acc_sum);
      case (r_op)
        OP_VADD: w_res[l] = sat_dw(sext_dw(a) + sext_dw(b));
        OP_VMUL: w_res[l] = sat_dw(prod_w >>> FRACBITS);
        OP_VMAC: w_res[l] = sat_dw({w_acc_nx[l][ACCWIDTH-1], w_acc_nx[l]} >>> FRACBITS);
        default: w_res[l] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g    <= '0;
      r_op   <= OP_VADD;
      r_dst  <= '0;
      r_va   <= '0;
      r_vb   <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
      r_we3  <= 1'b0;
      r_ra3  <= '0;
      r_wd3  <= '0;
      for (int i = 0; i < VECTORSPERREG; i++) r_acc[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_we3  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_dst <= rd_dst;
            r_va  <= va;
            r_vb  <= vb;
            r_g   <= '0;
          end
        end
        // ---- EXEC: one lane group per cycle ----
        S_EXEC: begin
          for (int l = 0; l < LANESPERCYCLE; l++) begin
            if (r_op != OP_VCLR) r_res[w_lidx[l]*DATAWIDTH +: DATAWIDTH] <= w_res[l];
            if (r_op == OP_VMAC) r_acc[w_lidx[l]] <= w_acc_nx[l];
            else if (r_op == OP_VCLR) r_acc[w_lidx[l]] <= '0;
          end
          r_g <= r_g + 1'b1;
        end
        // ---- WB: registered write-back, stable across the register file's negedge ----
        S_WB: begin
          r_done <= 1'b1;
          r_g    <= '0;
          if (r_op != OP_VCLR) begin
            r_we3 <= 1'b1;
            r_ra3 <= r_dst;
            r_wd3 <= r_res;
          end
        end
        default: r_g <= '0;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign we3  = r_we3;
  assign ra3  = r_ra3;
  assign wd3  = r_wd3;

endmodule

// File: tb/tb_vector_mac_unit.sv
// Directed bench for vector_mac_unit: hand-computed lane results checked with immediate assertions.
module tb_vector_mac_unit;

  localparam int VL = 16;
  localparam int DW = 8;
  localparam int VW = VL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [4:0]    rd_dst;
  logic [VW-1:0] va, vb;
  logic          busy, done, we3;
  logic [4:0]    ra3;
  logic [VW-1:0] wd3;

  int checks = 0;
  int errors = 0;

  vector_mac_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd_dst(rd_dst),
    .va(va), .vb(vb), .busy(busy), .done(done), .we3(we3), .ra3(ra3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [7:0] b);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch at edge 0, then check busy through EXEC/WB and the write-back pulse after edge 5
  task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] dst,
                        input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic exp_we, input logic [4:0] exp_ra, input logic [VW-1:0] exp_wd);
    op = o; rd_dst = dst; va = a; vb = b; start = 1'b1;
    tick();
    start = 1'b0; op = ~o; rd_dst = ~dst; va = ~a; vb = b ^ fill(8'h5A);
    check({tag, "_busy_e0"}, VW'(busy), VW'(1));
    check({tag, "_done_e0"}, VW'(done), VW'(0));
    repeat (4) tick();
    check({tag, "_busy_e4"}, VW'(busy), VW'(1));
    check({tag, "_we3_e4"}, VW'(we3), VW'(0));
    tick();
    check({tag, "_done"}, VW'(done), VW'(1));
    check({tag, "_we3"}, VW'(we3), VW'(exp_we));
    check({tag, "_ra3"}, VW'(ra3), VW'(exp_ra));
    check({tag, "_wd3"}, wd3, exp_wd);
    check({tag, "_busy_wb"}, VW'(busy), VW'(0));
    tick();
    check({tag, "_done_off"}, VW'(done), VW'(0));
    check({tag, "_we3_off"}, VW'(we3), VW'(0));
    check({tag, "_wd3_hold"}, wd3, exp_wd);
  endtask

  initial begin
    logic [VW-1:0] a2, b2, e2, a4, b4, e4;
    int dcount;

    rst = 1'b1; start = 1'b0; op = 2'b00; rd_dst = '0; va = '0; vb = '0;
    repeat (2) tick();
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_we3", VW'(we3), VW'(0));
    check("rst_ra3", VW'(ra3), VW'(0));
    check("rst_wd3", wd3, '0);
    rst = 1'b0;
    tick();

    // 1: VADD saturating high
    run_op("vadd_sat", 2'b00, 5'd3, fill(8'h70), fill(8'h20), 1'b1, 5'd3, fill(8'h7F));

    // 2: VMUL with saturation and a negative product
    a2 = fill(8'h40); b2 = fill(8'h40); e2 = fill(8'h20);
    a2[0 +: 8] = 8'h80; b2[0 +: 8] = 8'h80; e2[0 +: 8] = 8'h7F;
    a2[8 +: 8] = 8'h40; b2[8 +: 8] = 8'hC0; e2[8 +: 8] = 8'hE0;
    run_op("vmul", 2'b01, 5'd7, a2, b2, 1'b1, 5'd7, e2);

    // 3: VCLR leaves write port idle and wd3/ra3 held, then accumulate three times
    run_op("vclr", 2'b11, 5'd9, fill(8'h11), fill(8'h22), 1'b0, 5'd7, e2);
    run_op("vmac1", 2'b10, 5'd10, fill(8'h40), fill(8'h40), 1'b1, 5'd10, fill(8'h20));
    run_op("vmac2", 2'b10, 5'd11, fill(8'h40), fill(8'h40), 1'b1, 5'd11, fill(8'h40));
    run_op("vmac3", 2'b10, 5'd12, fill(8'h40), fill(8'h40), 1'b1, 5'd12, fill(8'h60));

    // 4: lane ordering, lane i = i + (-1)
    for (int i = 0; i < VL; i++) begin
      a4[i*DW +: DW] = 8'(i);
      b4[i*DW +: DW] = 8'hFF;
      e4[i*DW +: DW] = 8'(i - 1);
    end
    run_op("vadd_order", 2'b00, 5'd21, a4, b4, 1'b1, 5'd21, e4);

    // 5: start held high with VMUL during a VADD, through the done cycle
    op = 2'b00; rd_dst = 5'd5; va = fill(8'h10); vb = fill(8'h05); start = 1'b1;
    tick();
    op = 2'b01; va = fill(8'h40); vb = fill(8'h40);
    dcount = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (done) dcount++;
    end
    check("ign_wd3", wd3, fill(8'h15));
    check("ign_ra3", VW'(ra3), VW'(5));
    tick();
    start = 1'b0;
    check("ign_busy_after_wb", VW'(busy), VW'(0));
    for (int e = 0; e < 8; e++) begin
      tick();
      if (done) dcount++;
    end
    check("ign_done_count", VW'(dcount), VW'(1));

    // 6: reset during EXEC g=2 of a VMAC
    op = 2'b10; rd_dst = 5'd17; va = fill(8'h40); vb = fill(8'h40); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #2;
    check("mid_rst_busy", VW'(busy), VW'(0));
    check("mid_rst_done", VW'(done), VW'(0));
    check("mid_rst_we3", VW'(we3), VW'(0));
    check("mid_rst_ra3", VW'(ra3), VW'(0));
    check("mid_rst_wd3", wd3, '0);
    tick();
    rst = 1'b0;
    dcount = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (we3 || done) dcount++;
    end
    check("mid_rst_no_wb", VW'(dcount), VW'(0));
    run_op("vmac_after_rst", 2'b10, 5'd18, fill(8'h40), fill(8'h40), 1'b1, 5'd18, fill(8'h20));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
